// File: rtl/key_hit_encoder_if.sv
// key_hit_encoder_if
// Valid/ready hit channel from the button front end to the game core.
//   hit_valid : producer -> consumer, a key index is presented
//   hit_idx   : producer -> consumer, pressed key index 0..3, held while valid
//   hit_ready : consumer -> producer, transfer on an edge with valid & ready
// master = key_hit_encoder (producer), slave = game core (consumer).
interface key_hit_encoder_if;
  logic       hit_valid;
  logic [1:0] hit_idx;
  logic       hit_ready;

  modport master (
    output hit_valid,
    output hit_idx,
    input  hit_ready
  );

  modport slave (
    input  hit_valid,
    input  hit_idx,
    output hit_ready
  );
endinterface

// File: rtl/key_hit_encoder.sv
// key_hit_encoder
// Player-input front end for the whack-a-mole game. Synchronises and
// debounces four raw active-low push buttons, turns each press into a 2-bit
// key index and hands it to the game core over a valid/ready channel.
//
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   RESET_N   in   synchronous active-low reset
//   KEY[3:0]  in   raw buttons, active-low, asynchronous
//   hit       mst  hit_valid / hit_idx / hit_ready channel (key_hit_encoder_if)
//   key_down  out  debounced level per key, 1 = held
//   hit_drop  out  one-cycle pulse when a press is discarded (key already pending)
//
// Build option: define KEY_DEBOUNCE_EN to include the per-key debounce
// counters. Without it the debounced level follows the synchroniser directly
// (fast-simulation build, behaves like DEBOUNCE_CYCLES = 1).
//
// Output stage states:
//   state   | meaning
//   IDLE    | nothing presented; loads lowest pending key when any is pending
//   PRESENT | hit_idx presented with hit_valid=1; refills back-to-back on transfer
module key_hit_encoder #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [3:0]          KEY,
  key_hit_encoder_if.master   hit,
  output logic [3:0]          key_down,
  output logic                hit_drop
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_cfg
    $error("key_hit_encoder: DEBOUNCE_CYCLES outside 1..2^CNT_W-1");
  end

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  logic [3:0] sync1_q, sync2_q;
  logic [3:0] stable_q, stable_d;
  logic [3:0] pend_q, pend_d;
  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       hit_drop_q, hit_drop_d;

  // ---------------- debounce ----------------
`ifdef KEY_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised level disagrees with the
  // debounced one; any agreement restarts the qualification window.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_TC) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    stable_d = sync2_q;
  end
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      sync1_q  <= 4'hF;
      sync2_q  <= 4'hF;
      stable_q <= 4'hF;
    end else begin
      sync1_q  <= KEY;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
    end
  end

  // ---------------- pending + output stage ----------------
  logic [3:0] press, clr, presented, keep, drop;
  logic [1:0] low;
  logic       xfer;

  always_comb begin
    low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend_q[i]) low = 2'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr        = '0;
    presented  = '0;
    xfer       = (state_q == PRESENT) && hit.hit_ready;

    case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          idx_d    = low;
          clr[low] = 1'b1;
          state_d  = PRESENT;
        end
      end
      PRESENT: begin
        if (xfer) begin
          if (pend_q != '0) begin
            idx_d    = low;
            clr[low] = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Press is taken from the debounce update itself so the event lands in
    // pend on the same edge stable flips.
    press = stable_q & ~stable_d;

    if ((state_q == PRESENT) && !xfer) presented[idx_q] = 1'b1;

    // A clear on this edge frees the slot, so a coincident press re-arms it.
    keep       = pend_q & ~clr;
    drop       = press & (keep | presented);
    pend_d     = keep | (press & ~drop);
    hit_drop_d = |drop;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      pend_q     <= '0;
      hit_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      hit_drop_q <= hit_drop_d;
    end
  end

  assign hit.hit_valid = (state_q == PRESENT);
  assign hit.hit_idx   = idx_q;
  assign key_down      = ~stable_q;
  assign hit_drop      = hit_drop_q;

endmodule

// File: tb/tb_key_hit_encoder.sv
// Bench for key_hit_encoder: behavioural model plus directed scenarios.
module tb_key_hit_encoder;

  localparam int DEB = 4;
  // Effective qualification length: without the debounce build the level
  // follows the synchroniser, i.e. behaves like a one-cycle window.
  localparam int L = `ifdef KEY_DEBOUNCE_EN DEB `else 1 `endif ;

  logic       clk;
  logic       RESET_N;
  logic [3:0] KEY;
  logic [3:0] key_down;
  logic       hit_drop;

  key_hit_encoder_if hit_if ();

  key_hit_encoder #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (4)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (RESET_N),
    .KEY      (KEY),
    .hit      (hit_if),
    .key_down (key_down),
    .hit_drop (hit_drop)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int xfers    = 0;
  bit chk_en   = 0;

  // ---------------- model ----------------
  // Level per key flips once the synchronised input has disagreed with it for
  // L sampled edges in a row; a 1->0 flip is a press. Presses queue into a
  // pending set and are presented lowest-index first, one per transfer.
  logic [3:0] m_s1, m_s2, m_stable, m_pend;
  logic       m_valid, m_drop;
  logic [1:0] m_idx;
  logic [3:0] hist [$];

  logic [3:0] nstab, press, cleared, busy, drp;
  logic       xfer, all_diff;
  int         lo;

  always @(posedge clk) begin
    if (!RESET_N) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_stable = 4'hF; m_pend = 4'h0;
      m_valid = 1'b0; m_idx = 2'd0; m_drop = 1'b0;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > L) hist.delete(0);
      nstab = m_stable;
      if (hist.size() == L) begin
        for (int i = 0; i < 4; i++) begin
          all_diff = 1'b1;
          foreach (hist[k]) if (hist[k][i] == m_stable[i]) all_diff = 1'b0;
          if (all_diff) nstab[i] = ~m_stable[i];
        end
      end
      press   = m_stable & ~nstab;
      xfer    = m_valid && hit_if.hit_ready;
      cleared = 4'h0;
      busy    = 4'h0;
      if (!m_valid || xfer) begin
        if (m_pend != 4'h0) begin
          lo = 0;
          for (int i = 3; i >= 0; i--) if (m_pend[i]) lo = i;
          cleared[lo] = 1'b1;
          m_idx   = 2'(lo);
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end else begin
        busy[m_idx] = 1'b1;
      end
      drp      = press & ((m_pend & ~cleared) | busy);
      m_pend   = (m_pend & ~cleared) | (press & ~drp);
      m_drop   = |drp;
      m_stable = nstab;
      m_s2     = m_s1;
      m_s1     = KEY;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (hit_if.hit_valid !== m_valid || hit_if.hit_idx !== m_idx ||
          key_down !== ~m_stable || hit_drop !== m_drop) begin
        n_err++;
        $display("FAIL model_cmp t=%0t got v=%b idx=%0d kd=%b drop=%b expected v=%b idx=%0d kd=%b drop=%b",
                 $time, hit_if.hit_valid, hit_if.hit_idx, key_down, hit_drop,
                 m_valid, m_idx, ~m_stable, m_drop);
      end
      if (RESET_N && hit_if.hit_valid && hit_if.hit_ready) xfers++;
    end
  end

  // ---------------- directed ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  int x0;

  initial begin
    RESET_N = 1'b0;
    KEY = 4'hF;
    hit_if.hit_ready = 1'b0;
    tick(2);
    chk_en = 1;
    check("rst_valid", hit_if.hit_valid, 0);
    check("rst_idx", hit_if.hit_idx, 0);
    check("rst_key_down", key_down, 0);
    check("rst_drop", hit_drop, 0);
    RESET_N = 1'b1;
    tick(3);

    // single press of key 1, consumer always ready
    hit_if.hit_ready = 1'b1;
    KEY = 4'b1101;
    tick(1 + L);
    check("single_kd_before", key_down, 0);
    tick(1);
    check("single_kd", key_down, 4'b0010);
    check("single_valid_early", hit_if.hit_valid, 0);
    tick(1);
    check("single_valid", hit_if.hit_valid, 1);
    check("single_idx", hit_if.hit_idx, 1);
    tick(1);
    check("single_valid_off", hit_if.hit_valid, 0);
    KEY = 4'hF;
    tick(L + 4);
    check("release_kd", key_down, 0);

    // bounce on key 0 for three cycles
    x0 = xfers;
    KEY = 4'b1110;
    tick(3);
    KEY = 4'hF;
    tick(L + 8);
    check("bounce_xfers", xfers - x0, `ifdef KEY_DEBOUNCE_EN 0 `else 1 `endif );
    check("bounce_kd", key_down, 0);

    // all four pressed together, consumer stalled
    hit_if.hit_ready = 1'b0;
    KEY = 4'b0000;
    tick(2 + L);
    check("simul_kd", key_down, 4'hF);
    check("simul_valid_early", hit_if.hit_valid, 0);
    tick(1);
    check("simul_valid", hit_if.hit_valid, 1);
    check("simul_idx0", hit_if.hit_idx, 0);
    tick(3);
    check("simul_hold_idx0", hit_if.hit_idx, 0);
    hit_if.hit_ready = 1'b1;
    tick(1);
    check("simul_idx1", hit_if.hit_idx, 1);
    tick(1);
    check("simul_idx2", hit_if.hit_idx, 2);
    tick(1);
    check("simul_idx3", hit_if.hit_idx, 3);
    check("simul_valid3", hit_if.hit_valid, 1);
    tick(1);
    check("simul_done", hit_if.hit_valid, 0);
    KEY = 4'hF;
    tick(L + 4);

    // second press of a key already presented is dropped
    hit_if.hit_ready = 1'b0;
    KEY = 4'b1011;
    tick(3 + L);
    check("drop_valid", hit_if.hit_valid, 1);
    check("drop_idx", hit_if.hit_idx, 2);
    KEY = 4'hF;
    tick(L + 4);
    KEY = 4'b1011;
    tick(1 + L);
    check("drop_pre", hit_drop, 0);
    tick(1);
    check("drop_pulse", hit_drop, 1);
    check("drop_idx_held", hit_if.hit_idx, 2);
    tick(1);
    check("drop_post", hit_drop, 0);
    x0 = xfers;
    hit_if.hit_ready = 1'b1;
    tick(6);
    check("drop_one_xfer", xfers - x0, 1);
    check("drop_idle", hit_if.hit_valid, 0);
    KEY = 4'hF;
    tick(L + 4);

    // reset while presenting key 0 with key 3 pending
    hit_if.hit_ready = 1'b0;
    KEY = 4'b0110;
    tick(3 + L);
    check("pre_rst_valid", hit_if.hit_valid, 1);
    check("pre_rst_idx", hit_if.hit_idx, 0);
    RESET_N = 1'b0;
    KEY = 4'hF;
    tick(1);
    check("mid_rst_valid", hit_if.hit_valid, 0);
    check("mid_rst_kd", key_down, 0);
    check("mid_rst_idx", hit_if.hit_idx, 0);
    RESET_N = 1'b1;
    hit_if.hit_ready = 1'b1;
    x0 = xfers;
    tick(L + 10);
    check("post_rst_xfers", xfers - x0, 0);

    // key held through reset registers exactly once
    RESET_N = 1'b0;
    KEY = 4'b1101;
    tick(2);
    RESET_N = 1'b1;
    x0 = xfers;
    tick(L + 8);
    check("held_rst_xfers", xfers - x0, 1);
    KEY = 4'hF;
    tick(L + 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
